// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with rising-edge write strobe, registered status flags and cts hysteresis.
// Optional sticky overflow flag enabled by defining UART_RX_FIFO_OVF_FLAG_EN.
module uart_rx_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned HIGH_WATER = 12,
    parameter int unsigned LOW_WATER  = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     cts,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] HI_CNT   = (AW+1)'(HIGH_WATER);
    localparam logic [AW:0] LO_CNT   = (AW+1)'(LOW_WATER);

    typedef enum logic {SEND, HOLD} cts_state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          rx_ready_q;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q, empty_q, full_q, cts_q;
    cts_state_e    state_q, state_d;
    logic          wr_req, wr_acc, rd_acc;

    // Full/empty come from count; a write at full is dropped even if a read frees a slot.
    assign wr_req = rx_ready & ~rx_ready_q;
    assign wr_acc = wr_req & (count_q != FULL_CNT);
    assign rd_acc = rd_en & (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - (AW+1)'(1);
        end
        state_d = state_q;
        case (state_q)
            SEND:    if (count_d >= HI_CNT) state_d = HOLD;
            HOLD:    if (count_d <= LO_CNT) state_d = SEND;
            default: state_d = SEND;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && wr_acc) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Edge register resets high so an rx_ready held across reset release is not written.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_ready_q <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            state_q    <= SEND;
            cts_q      <= 1'b1;
        end else begin
            rx_ready_q <= rx_ready;
            rd_valid_q <= rd_acc;
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FULL_CNT);
            state_q <= state_d;
            cts_q   <= (state_d == SEND);
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign cts      = cts_q;

`ifdef UART_RX_FIFO_OVF_FLAG_EN
    logic ovf_q;
    // Set wins over clear when both happen on the same edge.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ovf_q <= 1'b0;
        end else if (wr_req && !wr_acc) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end
    assign overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule
